awg_dds_core: RTL and testbench

Parametrised DDS waveform engine, next generation of the AWG generator. Tuning word replaces the frequency divide. Shadow config registers are applied only at phase wrap, so updates are glitch-free. Adds start/stop control, phase-coherent stop, burst mode and output saturation. Sits between the host config interface and the DAC driver.

---
 rtl/awg_pkg.sv | 31 +++
 rtl/awg_sine_rom.sv | 28 ++
 rtl/awg_dds_core.sv | 252 +++++++++++++++++++++++++
 tb/tb_awg_dds_core.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/awg_pkg.sv
// Shared types and sine-table generator for the AWG DDS engine.
// Pure declarations: no latency, no flow control.
package awg_pkg;

    typedef enum logic [1:0] {
        SINE   = 2'b00,
        TRI    = 2'b01,
        SAW    = 2'b10,
        SQUARE = 2'b11
    } wave_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STOP = 2'b10
    } awg_state_t;

    localparam real AWG_PI = 3.14159265358979323846;

    // Unsigned offset-binary sine point: mid-scale plus rounded signed amplitude.
    function automatic int sine_point(input int d, input int l, input int i);
        real peak;
        real r;
        peak = real'((1 << (d - 1)) - 1);
        r    = peak * $sin(2.0 * AWG_PI * real'(i) / real'(1 << l));
        if (r >= 0.0)
            return (1 << (d - 1)) + $rtoi(r + 0.5);
        return (1 << (d - 1)) - $rtoi(0.5 - r);
    endfunction

endpackage

// File: rtl/awg_sine_rom.sv
// Sine lookup ROM, one registered read port (pipeline stage 2).
// Latency 1 clk from idx to dat; no backpressure, reads every cycle.
module awg_sine_rom
    import awg_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int LUT_AW = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LUT_AW-1:0] idx,
    output logic [DATA_W-1:0] dat
);

    logic [DATA_W-1:0] tab [2**LUT_AW];

    for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_tab
        assign tab[g] = DATA_W'(sine_point(DATA_W, LUT_AW, g));
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            dat <= '0;
        else
            dat <= tab[idx];
    end

endmodule

// File: rtl/awg_dds_core.sv
// DDS waveform engine with shadowed config, burst/stop control and saturation (optional AWG_SWEEP_EN sweep); 3 clk acc-to-sample.
// cfg_ready low while the shadow is pending (freed at wrap or in IDLE); output has no backpressure.
module awg_dds_core
    import awg_pkg::*;
#(
    parameter int DATA_W  = 10,
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 7,
    parameter int BURST_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_wave,
    input  logic [PHASE_W-1:0] cfg_fcw,
    input  logic [DATA_W-1:0]  cfg_amp,
    input  logic [DATA_W-1:0]  cfg_offset,
    input  logic [BURST_W-1:0] cfg_burst,
`ifdef AWG_SWEEP_EN
    input  logic [PHASE_W-1:0] cfg_sweep_step,
    input  logic [PHASE_W-1:0] cfg_sweep_stop,
`endif
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic [DATA_W-1:0]  wave_out,
    output logic               out_valid
);

    typedef struct packed {
        wave_sel_t          wave;
        logic [PHASE_W-1:0] fcw;
        logic [DATA_W-1:0]  amp;
        logic [DATA_W-1:0]  offset;
        logic [BURST_W-1:0] burst;
`ifdef AWG_SWEEP_EN
        logic [PHASE_W-1:0] sweep_step;
        logic [PHASE_W-1:0] sweep_stop;
`endif
    } cfg_t;

    cfg_t               cfg_in;
    cfg_t               shd;
    cfg_t               act;
    logic               shd_vld;
    logic               xfer;

    awg_state_t         state;
    awg_state_t         state_nxt;
    logic               running;

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W:0]   acc_sum;
    logic               wrap;
    logic [BURST_W-1:0] burst_cnt;
    logic               burst_last;

    always_comb begin
        cfg_in            = '0;
        cfg_in.wave       = wave_sel_t'(cfg_wave);
        cfg_in.fcw        = cfg_fcw;
        cfg_in.amp        = cfg_amp;
        cfg_in.offset     = cfg_offset;
        cfg_in.burst      = cfg_burst;
`ifdef AWG_SWEEP_EN
        cfg_in.sweep_step = cfg_sweep_step;
        cfg_in.sweep_stop = cfg_sweep_stop;
`endif
    end

    assign cfg_ready  = !shd_vld;
    assign acc_sum    = {1'b0, acc} + {1'b0, act.fcw};
    assign wrap       = running && acc_sum[PHASE_W];
    assign xfer       = shd_vld && (!running || wrap);
    assign burst_last = wrap && (act.burst != '0) && (burst_cnt == act.burst - BURST_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shd_vld <= 1'b0;
            shd     <= '0;
        end else if (cfg_valid && cfg_ready) begin
            shd_vld <= 1'b1;
            shd     <= cfg_in;
        end else if (xfer) begin
            shd_vld <= 1'b0;
        end
    end

`ifdef AWG_SWEEP_EN
    logic [PHASE_W:0]   sweep_sum;
    logic [PHASE_W-1:0] swept_fcw;
    assign sweep_sum = {1'b0, act.fcw} + {1'b0, act.sweep_step};
    assign swept_fcw = (sweep_sum > {1'b0, act.sweep_stop}) ? act.sweep_stop
                                                             : sweep_sum[PHASE_W-1:0];
`endif

    // A transfer landing on a wrap takes priority over the sweep increment.
    always_ff @(posedge clk) begin
        if (!rst_n)
            act <= '0;
        else if (xfer)
            act <= shd;
`ifdef AWG_SWEEP_EN
        else if (wrap && state == RUN && act.sweep_step != '0)
            act.fcw <= swept_fcw;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN: begin
                if (burst_last)
                    state_nxt = IDLE;
                else if (stop)
                    state_nxt = (act.fcw == '0) ? IDLE : STOP;
            end
            STOP:    if (wrap || act.fcw == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        running = (state != IDLE);
        busy    = running;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            acc <= '0;
        else if (!running || state_nxt == IDLE)
            acc <= '0;
        else
            acc <= acc_sum[PHASE_W-1:0];
    end

    // Counting restarts when a new config lands so its burst length applies from its first period.
    always_ff @(posedge clk) begin
        if (!rst_n)
            burst_cnt <= '0;
        else if (!running || state_nxt == IDLE || xfer)
            burst_cnt <= '0;
        else if (wrap)
            burst_cnt <= burst_cnt + BURST_W'(1);
    end

    // Stage 1: phase index plus the config that belongs to this sample.
    logic              s1_vld;
    logic [LUT_AW-1:0] s1_idx;
    wave_sel_t         s1_wave;
    logic [DATA_W-1:0] s1_amp;
    logic [DATA_W-1:0] s1_off;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_idx  <= '0;
            s1_wave <= SINE;
            s1_amp  <= '0;
            s1_off  <= '0;
        end else begin
            s1_vld  <= running;
            s1_idx  <= acc[PHASE_W-1 -: LUT_AW];
            s1_wave <= act.wave;
            s1_amp  <= act.amp;
            s1_off  <= act.offset;
        end
    end

    logic [LUT_AW-2:0] tri_idx;
    logic [DATA_W-1:0] s1_lin;

    always_comb begin
        tri_idx = s1_idx[LUT_AW-1] ? ~s1_idx[LUT_AW-2:0] : s1_idx[LUT_AW-2:0];
        s1_lin  = '0;
        unique case (s1_wave)
            TRI:     s1_lin = DATA_W'(tri_idx) << (DATA_W - LUT_AW + 1);
            SAW:     s1_lin = DATA_W'(s1_idx) << (DATA_W - LUT_AW);
            SQUARE:  s1_lin = {DATA_W{~s1_idx[LUT_AW-1]}};
            default: s1_lin = '0;
        endcase
    end

    // Stage 2: raw sample, ROM for sine, computed shapes registered alongside.
    logic              s2_vld;
    wave_sel_t         s2_wave;
    logic [DATA_W-1:0] s2_lin;
    logic [DATA_W-1:0] s2_amp;
    logic [DATA_W-1:0] s2_off;
    logic [DATA_W-1:0] rom_dat;

    awg_sine_rom #(
        .DATA_W (DATA_W),
        .LUT_AW (LUT_AW)
    ) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .idx   (s1_idx),
        .dat   (rom_dat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_wave <= SINE;
            s2_lin  <= '0;
            s2_amp  <= '0;
            s2_off  <= '0;
        end else begin
            s2_vld  <= s1_vld;
            s2_wave <= s1_wave;
            s2_lin  <= s1_lin;
            s2_amp  <= s1_amp;
            s2_off  <= s1_off;
        end
    end

    // Stage 3: scale by amp/2^DATA_W, add offset, clamp at full scale.
    logic [DATA_W-1:0]   s2_raw;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   scaled;
    logic [DATA_W:0]     s3_sum;
    logic [DATA_W-1:0]   s3_nxt;

    always_comb begin
        s2_raw = (s2_wave == SINE) ? rom_dat : s2_lin;
        prod   = (2*DATA_W)'(s2_raw) * (2*DATA_W)'(s2_amp);
        scaled = DATA_W'(prod >> DATA_W);
        s3_sum = {1'b0, scaled} + {1'b0, s2_off};
        s3_nxt = s3_sum[DATA_W] ? {DATA_W{1'b1}} : s3_sum[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            wave_out  <= '0;
        end else begin
            out_valid <= s2_vld;
            wave_out  <= s3_nxt;
        end
    end

endmodule

// File: tb/tb_awg_dds_core.sv
// Directed bench for awg_dds_core: expected samples queued at stimulus time, checked as they emerge.
module tb_awg_dds_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_wave;
    logic [31:0] cfg_fcw;
    logic [9:0]  cfg_amp;
    logic [9:0]  cfg_offset;
    logic [15:0] cfg_burst;
    logic        start;
    logic        stop;
    logic        busy;
    logic [9:0]  wave_out;
    logic        out_valid;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    bit          mon_en = 1'b0;
    int          n;

    awg_dds_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_wave   (cfg_wave),
        .cfg_fcw    (cfg_fcw),
        .cfg_amp    (cfg_amp),
        .cfg_offset (cfg_offset),
        .cfg_burst  (cfg_burst),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .wave_out   (wave_out),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    // Reference sample for D=10, L=7; sine known only at quarter points.
    function automatic int model(input int wave, input int idx, input int amp, input int off);
        int raw;
        int s;
        case (wave)
            0: case (idx)
                   0:       raw = 512;
                   32:      raw = 1023;
                   64:      raw = 512;
                   96:      raw = 1;
                   default: raw = 0;
               endcase
            1:       raw = (((idx >= 64) ? (127 - idx) : idx) % 64) * 16;
            2:       raw = idx * 8;
            default: raw = (idx < 64) ? 1023 : 0;
        endcase
        s = ((raw * amp) >> 10) + off;
        return (s > 1023) ? 1023 : s;
    endfunction

    task automatic cyc(input int cnt);
        repeat (cnt) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push_run(input int wave, input int unsigned fcw, input int amp,
                            input int off, input int cnt);
        int unsigned acc = 0;
        for (int k = 0; k < cnt; k++) begin
            exp_q.push_back(32'(model(wave, int'(acc >> 25), amp, off)));
            acc += fcw;
        end
    endtask

    task automatic send_cfg(input int wave, input logic [31:0] fcw, input int amp,
                            input int off, input int burst);
        int w = 0;
        while (!cfg_ready && w < 2000) begin
            cyc(1);
            w++;
        end
        chk("cfg_ready_wait", {31'd0, cfg_ready}, 32'd1);
        cfg_valid  = 1'b1;
        cfg_wave   = 2'(wave);
        cfg_fcw    = fcw;
        cfg_amp    = 10'(amp);
        cfg_offset = 10'(off);
        cfg_burst  = 16'(burst);
        cyc(1);
        cfg_valid  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int cnt);
        cnt = 0;
        while (busy && cnt < limit) begin
            cyc(1);
            cnt++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wave_out"},  {22'd0, wave_out},  32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_busy"},      {31'd0, busy},      32'd0);
        chk({tag, "_cfg_ready"}, {31'd0, cfg_ready}, 32'd1);
    endtask

    task automatic chk_drain(input string tag);
        cyc(5);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en && out_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sample_extra: observed=%0d expected=none", wave_out);
            end
            if (exp_q.size() != 0) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                assert ({22'd0, wave_out} === e) else begin
                    errors++;
                    $error("FAIL sample: observed=%0d expected=%0d", wave_out, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_wave = '0; cfg_fcw = '0; cfg_amp = '0;
        cfg_offset = '0; cfg_burst = '0; start = 1'b0; stop = 1'b0;
        cyc(2);
        chk_reset_outputs("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        cyc(1);

        // stop is ignored while idle
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("stop_in_idle", {31'd0, busy}, 32'd0);

        // sawtooth, one period, first-sample latency
        push_run(2, 32'h0200_0000, 1023, 0, 128);
        send_cfg(2, 32'h0200_0000, 1023, 0, 1);
        chk("shadow_pending", {31'd0, cfg_ready}, 32'd0);
        cyc(1);
        chk("idle_xfer", {31'd0, cfg_ready}, 32'd1);
        pulse_start();
        chk("saw_busy", {31'd0, busy}, 32'd1);
        chk("lat_c0", {31'd0, out_valid}, 32'd0);
        cyc(2);
        chk("lat_c2", {31'd0, out_valid}, 32'd0);
        cyc(1);
        chk("lat_c3", {31'd0, out_valid}, 32'd1);
        chk("saw_first", {22'd0, wave_out}, 32'd0);
        wait_idle(1000, n);
        chk("saw_period", 32'(n + 3), 32'd128);
        chk_drain("saw_drain");

        // square with offset saturating; start and stop together: start wins
        push_run(3, 32'h0200_0000, 1023, 512, 128);
        send_cfg(3, 32'h0200_0000, 1023, 512, 1);
        cyc(1);
        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        chk("start_wins", {31'd0, busy}, 32'd1);
        wait_idle(1000, n);
        chk("square_period", 32'(n), 32'd128);
        chk_drain("square_drain");

        // triangle
        push_run(1, 32'h0200_0000, 1023, 0, 128);
        send_cfg(1, 32'h0200_0000, 1023, 0, 1);
        cyc(1);
        pulse_start();
        wait_idle(1000, n);
        chk("tri_period", 32'(n), 32'd128);
        chk_drain("tri_drain");

        // sine at quarter-period steps, two-period burst
        push_run(0, 32'h4000_0000, 1023, 0, 8);
        send_cfg(0, 32'h4000_0000, 1023, 0, 2);
        cyc(1);
        pulse_start();
        wait_idle(1000, n);
        chk("sine_burst", 32'(n), 32'd8);
        chk_drain("sine_drain");

        // burst of two periods
        push_run(2, 32'h0200_0000, 1023, 0, 256);
        send_cfg(2, 32'h0200_0000, 1023, 0, 2);
        cyc(1);
        pulse_start();
        wait_idle(1000, n);
        chk("burst2_len", 32'(n), 32'd256);
        chk_drain("burst2_drain");

        // config update mid-period takes effect at the wrap
        push_run(2, 32'h0200_0000, 1023, 0, 128);
        push_run(2, 32'h0100_0000, 1023, 0, 256);
        send_cfg(2, 32'h0200_0000, 1023, 0, 0);
        cyc(1);
        pulse_start();
        cyc(40);
        send_cfg(2, 32'h0100_0000, 1023, 0, 1);
        chk("upd_pending", {31'd0, cfg_ready}, 32'd0);
        cyc(85);
        chk("upd_prewrap", {31'd0, cfg_ready}, 32'd0);
        cyc(2);
        chk("upd_postwrap", {31'd0, cfg_ready}, 32'd1);
        wait_idle(1000, n);
        chk("upd_newperiod", 32'(n), 32'd256);
        chk_drain("upd_drain");

        // phase-coherent stop at idx 40
        push_run(2, 32'h0200_0000, 1023, 0, 128);
        send_cfg(2, 32'h0200_0000, 1023, 0, 0);
        cyc(1);
        pulse_start();
        cyc(40);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("stop_coherent", {31'd0, busy}, 32'd1);
        wait_idle(1000, n);
        chk("stop_at_wrap", 32'(n + 41), 32'd128);
        chk_drain("stop_drain");

        // stop with fcw=0 ends immediately
        push_run(2, 32'h0, 1023, 100, 11);
        send_cfg(2, 32'h0, 1023, 100, 0);
        cyc(1);
        pulse_start();
        cyc(10);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("stop_fcw0", {31'd0, busy}, 32'd0);
        chk_drain("stop0_drain");

        // reset in the middle of a run
        mon_en = 1'b0;
        send_cfg(2, 32'h0200_0000, 1023, 0, 0);
        cyc(1);
        pulse_start();
        cyc(20);
        rst_n = 1'b0;
        cyc(1);
        chk_reset_outputs("rst_mid");
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        chk_reset_outputs("rst_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
